// File: rtl/approx_mul_pkg.sv
// Shared constants and the bit-accurate reference model for the approximate multiplier.
package approx_mul_pkg;

  localparam int unsigned MAX_W           = 32;
  localparam int unsigned DEF_APPROX_ROWS = 6;
  localparam int unsigned N_PAIRS         = DEF_APPROX_ROWS / 2;
  localparam int unsigned HAS_ODD         = DEF_APPROX_ROWS % 2;

  function automatic int unsigned n_pairs(input int unsigned l);
    return l / 2;
  endfunction

  function automatic int unsigned has_odd(input int unsigned l);
    return l % 2;
  endfunction

  // Row 0 is the exact upper sum, then one row per merged pair, then the unpaired row.
  function automatic int unsigned num_rows(input int unsigned l);
    return n_pairs(l) + has_odd(l) + 1;
  endfunction

  // Column-by-column model of the product for operand width w and l approximated rows.
  function automatic logic [2*MAX_W-1:0] approx_ref(input logic [MAX_W-1:0] x,
                                                     input logic [MAX_W-1:0] y,
                                                     input logic             exact,
                                                     input int               w,
                                                     input int               l);
    logic [2*MAX_W-1:0] acc;
    logic               b0;
    logic               b1;
    acc = '0;
    for (int i = 0; i < w; i++) begin
      if (exact || i >= l || ((l % 2 == 1) && i == l - 1)) begin
        if (x[i]) acc = acc + ({{MAX_W{1'b0}}, y} << i);
      end
    end
    if (!exact) begin
      for (int k = 0; k < l / 2; k++) begin
        for (int c = 2 * k; c <= 2 * k + w; c++) begin
          b0 = 1'b0;
          b1 = 1'b0;
          if (c - 2 * k < w) b0 = x[2*k] & y[c-2*k];
          if (c - 2 * k - 1 >= 0 && c - 2 * k - 1 < w) b1 = x[2*k+1] & y[c-2*k-1];
          if (b0 | b1) acc = acc + ({{(2*MAX_W-1){1'b0}}, 1'b1} << c);
        end
      end
    end
    if (w < MAX_W) acc = acc & (({{(2*MAX_W-1){1'b0}}, 1'b1} << (2 * w)) - 1);
    return acc;
  endfunction

endpackage

// File: rtl/approx_pp_merge.sv
// Combinational partial-product stage: exact upper sum, pair-merged low rows, unpaired row.
module approx_pp_merge
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_ROWS = 6
) (
  input  logic [WIDTH-1:0]                                x,
  input  logic [WIDTH-1:0]                                y,
  input  logic                                            exact,
  output logic [num_rows(APPROX_ROWS)-1:0][2*WIDTH-1:0]   rows
);

  localparam int unsigned ZW       = 2 * WIDTH;
  localparam int unsigned NumPairs = n_pairs(APPROX_ROWS);
  localparam int unsigned HasOdd   = has_odd(APPROX_ROWS);

  logic [ZW-1:0] y_ext;
  assign y_ext = ZW'(y);

  assign rows[0] = (y_ext * ZW'(x >> APPROX_ROWS)) << APPROX_ROWS;

  for (genvar k = 0; k < NumPairs; k++) begin : g_pair
    logic [ZW-1:0] lo;
    logic [ZW-1:0] hi;
    assign lo = y_ext & {ZW{x[2*k]}};
    assign hi = (y_ext & {ZW{x[2*k+1]}}) << 1;
    // Exact beats add the pair; approximate beats OR it and lose the carries.
    assign rows[k+1] = (exact ? (lo + hi) : (lo | hi)) << (2 * k);
  end

  if (HasOdd != 0) begin : g_odd
    assign rows[NumPairs+1] = (y_ext & {ZW{x[APPROX_ROWS-1]}}) << (APPROX_ROWS - 1);
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined approximate/exact unsigned multiplier with valid/ready stream and sideband tag.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_ROWS = 6,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               exact,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int unsigned ZW    = 2 * WIDTH;
  localparam int unsigned NRows = num_rows(APPROX_ROWS);

  logic [NRows-1:0][ZW-1:0] rows;
  logic [STAGES-1:0]        valid_q;
  logic [STAGES-1:0]        can_load;
  logic [STAGES-1:0]        stage_in_valid;
  logic [TAG_W-1:0]         tag_q  [STAGES];
  logic [TAG_W-1:0]         tag_in [STAGES];
  logic [CNT_W-1:0]         cnt_q;
  logic                     in_fire;

  approx_pp_merge #(
    .WIDTH      (WIDTH),
    .APPROX_ROWS(APPROX_ROWS)
  ) u_merge (
    .x    (x),
    .y    (y),
    .exact(exact),
    .rows (rows)
  );

  // A stage can load if any stage at or after it is empty, or the output drains.
  always_comb begin
    logic full;
    can_load = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      full = 1'b1;
      for (int j = k; j < int'(STAGES); j++) full = full & valid_q[j];
      can_load[k] = out_ready | ~full;
    end
  end

  assign in_ready = can_load[0];
  assign in_fire  = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_link
    if (k == 0) begin : g_first
      assign stage_in_valid[k] = in_valid;
      assign tag_in[k]         = in_tag;
    end else begin : g_next
      assign stage_in_valid[k] = valid_q[k-1];
      assign tag_in[k]         = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) tag_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (can_load[k]) begin
          valid_q[k] <= stage_in_valid[k];
          if (stage_in_valid[k]) tag_q[k] <= tag_in[k];
        end
      end
    end
  end

  if (STAGES == 1) begin : g_single
    logic [ZW-1:0] sum;
    logic [ZW-1:0] sum_q;

    always_comb begin
      sum = '0;
      for (int r = 0; r < int'(NRows); r++) sum = sum + rows[r];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
      end else if (in_fire) begin
        sum_q <= sum;
      end
    end

    assign z = sum_q;
  end else begin : g_multi
    logic [NRows-1:0][ZW-1:0] rows_q;
    logic [ZW-1:0]            acc;
    logic [ZW-1:0]            acc_q [STAGES-1];

    always_comb begin
      acc = '0;
      for (int r = 0; r < int'(NRows); r++) acc = acc + rows_q[r];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rows_q <= '0;
        for (int j = 0; j < int'(STAGES) - 1; j++) acc_q[j] <= '0;
      end else begin
        if (in_fire) rows_q <= rows;
        if (can_load[1] && valid_q[0]) acc_q[0] <= acc;
        for (int j = 1; j < int'(STAGES) - 1; j++) begin
          if (can_load[j+1] && valid_q[j]) acc_q[j] <= acc_q[j-1];
        end
      end
    end

    assign z = acc_q[STAGES-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (in_fire && !exact && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop and compare.
module tb_approx_mul_pipe;
  import approx_mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT a: default parameters
  logic        a_in_valid, a_in_ready, a_exact, a_out_valid, a_out_ready;
  logic [7:0]  a_x, a_y;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [15:0] a_z, a_cnt;

  // DUT b (L=5, 3 stages, 4-bit counter) and c (L=0, 1 stage) share one input stream
  logic        bc_in_valid, bc_exact, b_in_ready, c_in_ready, b_out_valid, c_out_valid;
  logic        bc_out_ready;
  logic [7:0]  bc_x, bc_y;
  logic [3:0]  bc_tag, b_out_tag, c_out_tag, b_cnt;
  logic [15:0] b_z, c_z, c_cnt;

  approx_mul_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x), .y(a_y),
    .exact(a_exact), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .z(a_z), .out_tag(a_out_tag), .approx_cnt(a_cnt)
  );

  approx_mul_pipe #(.WIDTH(8), .APPROX_ROWS(5), .STAGES(3), .TAG_W(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(bc_in_valid), .in_ready(b_in_ready), .x(bc_x), .y(bc_y),
    .exact(bc_exact), .in_tag(bc_tag), .out_valid(b_out_valid), .out_ready(bc_out_ready),
    .z(b_z), .out_tag(b_out_tag), .approx_cnt(b_cnt)
  );

  approx_mul_pipe #(.WIDTH(8), .APPROX_ROWS(0), .STAGES(1), .TAG_W(4), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(bc_in_valid), .in_ready(c_in_ready), .x(bc_x), .y(bc_y),
    .exact(bc_exact), .in_tag(bc_tag), .out_valid(c_out_valid), .out_ready(bc_out_ready),
    .z(c_z), .out_tag(c_out_tag), .approx_cnt(c_cnt)
  );

  typedef struct {
    logic [15:0] z;
    logic [3:0]  tag;
    bit          chk_lat;
    int unsigned acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   a_pops = 0;
  int   bc_nx  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected none", nm);
  endtask

  task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic ex,
                        input logic [3:0] tag, input logic [15:0] zexp, input bit lat);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_x = x; a_y = y; a_exact = ex; a_in_tag = tag;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 50) begin fail("a_in_ready_timeout"); break; end
    end
    e.z = zexp; e.tag = tag; e.chk_lat = lat; e.acc = cyc;
    qa.push_back(e);
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_bc(input logic [7:0] x, input logic [7:0] y, input logic ex,
                         input logic [3:0] tag, input logic [15:0] zb, input logic [15:0] zc);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    bc_in_valid = 1'b1; bc_x = x; bc_y = y; bc_exact = ex; bc_tag = tag;
    forever begin
      @(negedge clk);
      if (b_in_ready && c_in_ready) break;
      n++;
      if (n > 50) begin fail("bc_in_ready_timeout"); break; end
    end
    e.tag = tag; e.chk_lat = 1'b0; e.acc = cyc;
    e.z = zb; qb.push_back(e);
    e.z = zc; qc.push_back(e);
    if (!ex) bc_nx++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin fail("drain_timeout"); break; end
    end
    @(negedge clk);
  endtask

  // Monitor a: scoreboard compare, latency, and hold-during-stall checks
  initial begin
    bit          held;
    logic [15:0] hz;
    logic [3:0]  ht;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("a_stall_valid", a_out_valid, 1'b1);
          check("a_stall_z", a_z, hz);
          check("a_stall_tag", a_out_tag, ht);
        end
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            fail("a_unexpected_output");
          end else begin
            e = qa.pop_front();
            check("a_z", a_z, e.z);
            check("a_tag", a_out_tag, e.tag);
            if (e.chk_lat) check("a_latency", cyc - e.acc, 2);
            a_pops++;
          end
        end
        held = a_out_valid && !a_out_ready;
        hz   = a_z;
        ht   = a_out_tag;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && b_out_valid && bc_out_ready) begin
        if (qb.size() == 0) fail("b_unexpected_output");
        else begin
          e = qb.pop_front();
          check("b_z", b_z, e.z);
          check("b_tag", b_out_tag, e.tag);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && c_out_valid && bc_out_ready) begin
        if (qc.size() == 0) fail("c_unexpected_output");
        else begin
          e = qc.pop_front();
          check("c_z", c_z, e.z);
          check("c_tag", c_out_tag, e.tag);
        end
      end
    end
  end

  initial begin
    int                 pops0;
    logic [63:0]        rb;
    logic [7:0]         rx, ry;
    logic               rex;
    bit                 seen;
    a_in_valid = 1'b0; a_x = '0; a_y = '0; a_exact = 1'b0; a_in_tag = '0; a_out_ready = 1'b1;
    bc_in_valid = 1'b0; bc_x = '0; bc_y = '0; bc_exact = 1'b0; bc_tag = '0;
    bc_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_z", a_z, 16'd0);
    check("rst_out_tag", a_out_tag, 4'd0);
    check("rst_cnt", a_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed products, hand-computed for W=8, L=6
    send_a(8'd255, 8'd255, 1'b0, 4'd1, 16'd59691, 1'b1);
    idle_a(); drain();
    check("cnt_after_approx", a_cnt, 16'd1);
    send_a(8'd255, 8'd255, 1'b1, 4'd2, 16'd65025, 1'b1);
    idle_a(); drain();
    check("cnt_after_exact", a_cnt, 16'd1);
    send_a(8'd3, 8'd3, 1'b0, 4'd3, 16'd7, 1'b1);
    send_a(8'd3, 8'd3, 1'b1, 4'd4, 16'd9, 1'b1);
    send_a(8'd3, 8'd1, 1'b0, 4'd5, 16'd3, 1'b1);
    idle_a(); drain();
    check("cnt_after_small", a_cnt, 16'd3);

    // Back-to-back with out_ready pattern 1,0,0,1
    pops0 = a_pops;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send_a(8'(t + 1), 8'(t + 2), 1'b1, 4'(t), 16'((t + 1) * (t + 2)), 1'b0);
        idle_a();
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          a_out_ready = (i % 4 == 0) || (i % 4 == 3);
        end
        a_out_ready = 1'b1;
      end
    join
    drain();
    check("stall_beats_delivered", a_pops - pops0, 8);

    // Reset with two beats parked in a stalled pipe
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    send_a(8'd200, 8'd100, 1'b0, 4'd9, 16'd0, 1'b0);
    send_a(8'd17, 8'd19, 1'b0, 4'd10, 16'd0, 1'b0);
    idle_a();
    @(negedge clk);
    check("pre_rst_cnt", a_cnt, 16'd5);
    check("pre_rst_valid", a_out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async_valid", a_out_valid, 1'b0);
    check("rst_async_cnt", a_cnt, 16'd0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("no_stale_after_rst", seen, 1'b0);
    check("cnt_after_rst", a_cnt, 16'd0);

    // L=5 / L=0 instances: directed, then random, then saturation
    send_bc(8'd255, 8'd255, 1'b0, 4'd1, 16'd63755, 16'd65025);
    send_bc(8'd3, 8'd3, 1'b0, 4'd2, 16'd7, 16'd9);
    send_bc(8'd255, 8'd255, 1'b1, 4'd3, 16'd65025, 16'd65025);
    @(posedge clk); #1;
    bc_in_valid = 1'b0;
    drain();
    check("b_cnt_directed", b_cnt, 4'd2);
    for (int i = 0; i < 60; i++) begin
      rx  = 8'($urandom_range(0, 255));
      ry  = 8'($urandom_range(0, 255));
      rex = 1'($urandom_range(0, 1));
      rb  = approx_ref({24'd0, rx}, {24'd0, ry}, rex, 8, 5);
      send_bc(rx, ry, rex, 4'(i), rb[15:0], 16'(rx) * 16'(ry));
    end
    for (int i = 0; i < 16; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rb = approx_ref({24'd0, rx}, {24'd0, ry}, 1'b0, 8, 5);
      send_bc(rx, ry, 1'b0, 4'(i), rb[15:0], 16'(rx) * 16'(ry));
    end
    @(posedge clk); #1;
    bc_in_valid = 1'b0;
    drain();
    check("b_cnt_saturated", b_cnt, 4'd15);
    check("c_cnt_total", c_cnt, 16'(bc_nx));

    check("queues_empty", 64'(qa.size() + qb.size() + qc.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
